// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter that owns the select of a shared 8:1
// single-bit mux. Each grant lasts up to HOLD_CYCLES cycles and is released
// early when its requester drops req. The grant, select and valid are
// registered; out is the selected data bit, gated by valid.
//
// Parameters:
//   HOLD_CYCLES  maximum cycles one grant is held (1..16, default 4)
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   req    [7:0] request vector, req[i] from requester i
//   in     [7:0] data bits, in[i] belongs to requester i
//   gnt    [7:0] registered one-hot grant, zero when idle
//   sel    [2:0] registered index of the granted requester (mux select)
//   valid  registered, high while a grant is active
//   out    combinational in[sel] gated by valid
// Configuration:
//   MUX8_ARB_FIXED_PRIO_EN  when defined, search always starts at index 0
//                           (fixed priority, lowest index wins)
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] in,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       valid,
    output logic       out
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       last;
    logic [2:0]       last_nxt;
    logic [2:0]       sel_nxt;
    logic [7:0]       gnt_nxt;
    logic             valid_nxt;
    logic [2:0]       ptr;
    logic [2:0]       win;
    logic             found;
    logic             rel;
    logic             take;

    // Search start: after the last grant in IDLE, after the current holder in
    // GRANT, so the current holder is examined last.
`ifdef MUX8_ARB_FIXED_PRIO_EN
    assign ptr = 3'd0;
`else
    assign ptr = (state == IDLE) ? (last + 3'd1) : (sel + 3'd1);
`endif

    // First requester at or after ptr (3-bit wrap); scanned from the far end
    // so the nearest hit is the one that sticks.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) begin
                found = 1'b1;
                win   = ptr + 3'(i);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        valid_nxt = valid;
        cnt_nxt   = cnt;
        last_nxt  = last;
        rel       = 1'b0;
        take      = 1'b0;

        case (state)
            IDLE: begin
                take = found;
            end
            GRANT: begin
                rel = !req[sel] || (cnt == '0);
                if (!rel) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (found) begin
                    take = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 8'h00;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A new winner is granted on this edge, with no idle bubble.
        if (take) begin
            state_nxt = GRANT;
            gnt_nxt   = 8'b1 << win;
            sel_nxt   = win;
            valid_nxt = 1'b1;
            cnt_nxt   = CNT_RELOAD;
            last_nxt  = win;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 8'h00;
            sel   <= 3'd0;
            valid <= 1'b0;
            cnt   <= '0;
            last  <= 3'd7;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            valid <= valid_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    assign out = valid & in[sel];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: self-checking bench for mux8_rr_arbiter. Two instances
// share req/in: one with HOLD_CYCLES=4 (directed and random scenarios) and
// one with HOLD_CYCLES=1 (random scenario). A behavioural model tracks the
// owner, cycles held so far and last winner for each instance.
module tb_mux8_rr_arbiter;

    localparam int unsigned H0 = 4;
    localparam int unsigned H1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] in;
    logic [7:0] gnt   [2];
    logic [2:0] sel   [2];
    logic       valid [2];
    logic       out   [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: owner (-1 idle), cycles held, last winner, sel.
    int m_owner [2];
    int m_held  [2];
    int m_last  [2];
    int m_sel   [2];

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.HOLD_CYCLES(H0)) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .in    (in),
        .gnt   (gnt[0]),
        .sel   (sel[0]),
        .valid (valid[0]),
        .out   (out[0])
    );

    mux8_rr_arbiter #(.HOLD_CYCLES(H1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .in    (in),
        .gnt   (gnt[1]),
        .sel   (sel[1]),
        .valid (valid[1]),
        .out   (out[1])
    );

    function automatic int hold_of(input int j);
        return (j == 0) ? int'(H0) : int'(H1);
    endfunction

    function automatic int search_start(input int prev);
        int s;
        s = (prev + 1) % 8;
`ifdef MUX8_ARB_FIXED_PRIO_EN
        s = 0;
`endif
        return s;
    endfunction

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt(input int j);
        logic [7:0] g;
        g = 8'h00;
        if (m_owner[j] >= 0) g[m_owner[j]] = 1'b1;
        return g;
    endfunction

    function automatic logic exp_out(input int j);
        return (m_owner[j] >= 0) ? in[m_owner[j]] : 1'b0;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_owner[j] = -1;
            m_held[j]  = 0;
            m_last[j]  = 7;
            m_sel[j]   = 0;
        end
    endtask

    // Advance the model by one clock edge using the current req.
    task automatic model_step();
        int w;
        for (int j = 0; j < 2; j++) begin
            w = -2;
            if (m_owner[j] < 0) begin
                if (req != 8'h00) w = pick(req, search_start(m_last[j]));
            end else if (!req[m_owner[j]] || m_held[j] == hold_of(j)) begin
                w = pick(req, search_start(m_owner[j]));
                if (w < 0) m_owner[j] = -1;
            end else begin
                m_held[j]++;
            end
            if (w >= 0) begin
                m_owner[j] = w;
                m_held[j]  = 1;
                m_last[j]  = w;
                m_sel[j]   = w;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'h00;
        in  = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (gnt[0] !== 8'h00) begin n_fail++; $display("FAIL reset_gnt: got %h want 00", gnt[0]); end
        n_checks++;
        if (sel[0] !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel[0]); end
        n_checks++;
        if (valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid[0]); end
        n_checks++;
        if (out[0] !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b want 0", out[0]); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        req = 8'h00;
        in  = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if (gnt[0] !== 8'h00 || valid[0] !== 1'b0 || out[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_c%0d: got gnt=%h valid=%b out=%b want 00/0/0", k, gnt[0], valid[0], out[0]);
            end
        end
    endtask

    task automatic test_two_req();
        int e;
        req = 8'h81;
        in  = 8'h80;
        for (int k = 0; k < 9; k++) begin
            cycle();
            e = (k < 4 || k == 8) ? 0 : 7;
            n_checks++;
            if (gnt[0] !== (8'b1 << e) || sel[0] !== 3'(e) || out[0] !== (e == 7)) begin
                n_fail++;
                $display("FAIL two_req_c%0d: got gnt=%h sel=%0d out=%b want gnt=%h sel=%0d out=%b",
                         k, gnt[0], sel[0], out[0], 8'b1 << e, e, (e == 7));
            end
            if (k == 5) begin
                in = 8'h00;
                #1;
                n_checks++;
                if (out[0] !== 1'b0) begin n_fail++; $display("FAIL two_req_comb_out: got %b want 0", out[0]); end
                in = 8'h80;
            end
        end
        req = 8'h00;
        cycle();
        n_checks++;
        if (valid[0] !== 1'b0) begin n_fail++; $display("FAIL two_req_release: valid got %b want 0", valid[0]); end
    endtask

    task automatic test_drop();
        req = 8'h04;
        in  = 8'h04;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_checks++;
            if (gnt[0] !== 8'h04 || out[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL drop_hold_c%0d: got gnt=%h out=%b want 04/1", k, gnt[0], out[0]);
            end
        end
        req = 8'h00;
        cycle();
        n_checks++;
        if (valid[0] !== 1'b0 || gnt[0] !== 8'h00 || sel[0] !== 3'd2 || out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: got valid=%b gnt=%h sel=%0d out=%b want 0/00/2/0", valid[0], gnt[0], sel[0], out[0]);
        end
        repeat (3) cycle();
        req = 8'h04;
        cycle();
        n_checks++;
        if (gnt[0] !== 8'h04 || valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_regrant: got gnt=%h valid=%b want 04/1", gnt[0], valid[0]);
        end
        req = 8'h00;
        cycle();
    endtask

    task automatic test_wrap();
        int e;
        req = 8'h40;
        in  = 8'h02;
        cycle();
        n_checks++;
        if (gnt[0] !== 8'h40) begin n_fail++; $display("FAIL wrap_first: got gnt=%h want 40", gnt[0]); end
        req = 8'h03;
        for (int k = 0; k < 6; k++) begin
            cycle();
            e = (k < 4) ? 0 : 1;
            n_checks++;
            if (gnt[0] !== (8'b1 << e) || sel[0] !== 3'(e) || out[0] !== (e == 1)) begin
                n_fail++;
                $display("FAIL wrap_c%0d: got gnt=%h sel=%0d out=%b want gnt=%h sel=%0d out=%b",
                         k, gnt[0], sel[0], out[0], 8'b1 << e, e, (e == 1));
            end
        end
        req = 8'h00;
        cycle();
    endtask

    task automatic test_fixed_prio();
        req = 8'h0A;
        in  = 8'h00;
        for (int k = 0; k < 12; k++) begin
            cycle();
            n_checks++;
            if (gnt[0] !== 8'h02 || sel[0] !== 3'd1) begin
                n_fail++;
                $display("FAIL fixed_prio_c%0d: got gnt=%h sel=%0d want 02/1", k, gnt[0], sel[0]);
            end
        end
        req = 8'h00;
        cycle();
    endtask

    task automatic test_async_reset();
        req = 8'h20;
        in  = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_checks++;
            if (gnt[0] !== 8'h20 || sel[0] !== 3'd5) begin
                n_fail++;
                $display("FAIL areset_grant_c%0d: got gnt=%h sel=%0d want 20/5", k, gnt[0], sel[0]);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (gnt[0] !== 8'h00 || valid[0] !== 1'b0 || sel[0] !== 3'd0 || out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: got gnt=%h valid=%b sel=%0d out=%b want 00/0/0/0",
                     gnt[0], valid[0], sel[0], out[0]);
        end
        #1;
        rst = 1'b0;
        model_reset();
        req = 8'hFF;
        cycle();
        n_checks++;
        if (gnt[0] !== 8'h01 || sel[0] !== 3'd0 || valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_first_grant: got gnt=%h sel=%0d valid=%b want 01/0/1", gnt[0], sel[0], valid[0]);
        end
        req = 8'h00;
        cycle();
    endtask

    task automatic test_random();
        rst = 1'b1;
        req = 8'h00;
        in  = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
            in = 8'($urandom);
            cycle();
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (gnt[j] !== exp_gnt(j)) begin
                    n_fail++;
                    $display("FAIL rand_gnt u%0d c%0d: got %h want %h", j, k, gnt[j], exp_gnt(j));
                end
                n_checks++;
                if (sel[j] !== 3'(m_sel[j])) begin
                    n_fail++;
                    $display("FAIL rand_sel u%0d c%0d: got %0d want %0d", j, k, sel[j], m_sel[j]);
                end
                n_checks++;
                if (valid[j] !== (m_owner[j] >= 0)) begin
                    n_fail++;
                    $display("FAIL rand_valid u%0d c%0d: got %b want %b", j, k, valid[j], (m_owner[j] >= 0));
                end
                n_checks++;
                if (out[j] !== exp_out(j)) begin
                    n_fail++;
                    $display("FAIL rand_out u%0d c%0d: got %b want %b", j, k, out[j], exp_out(j));
                end
            end
            in = 8'($urandom);
            #1;
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (out[j] !== exp_out(j)) begin
                    n_fail++;
                    $display("FAIL rand_comb_out u%0d c%0d: got %b want %b", j, k, out[j], exp_out(j));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle();
`ifdef MUX8_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_two_req();
        test_drop();
        test_wrap();
`endif
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
